// File: rtl/debounce_edge_pio.sv
// debounce_edge_pio
//
// Input PIO for the HPS lightweight bridge. Each of WIDTH raw input channels passes through a
// two-flop synchroniser and a per-channel debounce counter. An accepted edge of the selected
// polarity sets a sticky capture bit. Registers are reached over a 4-word Avalon-MM slave.
//
// Parameters:
//   WIDTH            number of input channels (1..32)
//   DEBOUNCE_CYCLES  cycles a new level must hold before it is accepted (>= 2)
//   EDGE_TYPE        0 rising, 1 falling, 2 either
//   RESET_VALUE      reset level of the synchroniser and debounced state
//
// Optional feature macro: DEBOUNCE_EDGE_PIO_IRQ_EN
//   defined     MASK register and level interrupt irq = registered |(capture & mask)
//   undefined   MASK reads 0 and ignores writes, irq tied to 0; capture/W1C still work
//
// Ports:
//   clk_clk        system clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   pio_in         raw asynchronous inputs
//   address        word address: 0 DATA (RO), 1 MASK (RW), 2 EDGE (W1C), 3 RAW (RO)
//   read, write    Avalon-MM strobes
//   writedata      write data
//   readdata       registered read data (1-cycle latency, held between reads)
//   irq            level interrupt

module debounce_edge_pio #(
   parameter int unsigned       WIDTH           = 4,
   parameter int unsigned       DEBOUNCE_CYCLES = 50000,
   parameter int unsigned       EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0]  RESET_VALUE     = '1
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [WIDTH-1:0] pio_in,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] capture_q, capture_d;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] mask_val;
   logic [WIDTH-1:0] wd_bits;
   logic [31:0]      rd_val;
   logic [31:0]      readdata_q;

   assign wd_bits = writedata[WIDTH-1:0];

   // Upper write-data bits carry no register state.
   logic unused_wd;
   assign unused_wd = ^writedata;

   // Two-flop synchroniser.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q <= RESET_VALUE;
         s_q     <= RESET_VALUE;
      end else begin
         sync1_q <= pio_in;
         s_q     <= sync1_q;
      end
   end

   // Per-channel debounce: any sample equal to the accepted level restarts the count.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = s_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         stable_q <= RESET_VALUE;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // Edge detection on the debounced level, in the same cycle it updates.
   always_comb begin
      edge_set = '0;
      if (EDGE_TYPE == 0) begin
         edge_set = stable_d & ~stable_q;
      end else if (EDGE_TYPE == 1) begin
         edge_set = ~stable_d & stable_q;
      end else begin
         edge_set = stable_d ^ stable_q;
      end
   end

   // W1C clear; a coincident set wins.
   always_comb begin
      edge_clr = '0;
      if (write && (address == 2'd2)) begin
         edge_clr = wd_bits;
      end
      capture_d = (capture_q & ~edge_clr) | edge_set;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         capture_q <= '0;
      end else begin
         capture_q <= capture_d;
      end
   end

`ifdef DEBOUNCE_EDGE_PIO_IRQ_EN
   logic [WIDTH-1:0] mask_q;
   logic             irq_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (write && (address == 2'd1)) begin
            mask_q <= wd_bits;
         end
         irq_q <= |(capture_q & mask_q);
      end
   end

   assign mask_val = mask_q;
   assign irq      = irq_q;
`else
   assign mask_val = '0;
   assign irq      = 1'b0;
`endif

   // Read mux sees pre-write state, so a simultaneous read returns the old value.
   always_comb begin
      rd_val = '0;
      case (address)
         2'd0:    rd_val = 32'(stable_q);
         2'd1:    rd_val = 32'(mask_val);
         2'd2:    rd_val = 32'(capture_q);
         default: rd_val = 32'(s_q);
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         readdata_q <= '0;
      end else if (read) begin
         readdata_q <= rd_val;
      end
   end

   assign readdata = readdata_q;

endmodule
